sha256_host_mem: RTL and testbench
==================================

# sha256_host_mem

Host-side responder for the simplified SHA-256 engine. It owns the single-port word memory the engine reads and writes, and answers the engine's `mem_*` requests with one-cycle registered reads. It sequences the engine's `start`/`done` handshake. It accepts the message from a host as a valid/ready word stream, then returns the 8-word digest on a second valid/ready stream.

## Interface
Parameters:
- `NUM_OF_WORDS`, default 20: message length in 32-bit words loaded per job; must match the engine instance.
- `DEPTH`, default 64: memory size in words; addresses `>= DEPTH` are out of range.
- `MSG_BASE`, default 16'h0000: word address of message word 0; driven on `message_addr`.
- `OUT_BASE`, default 16'h0020: word address of digest word 0; driven on `output_addr`.

Ports:
- `clk` in 1: single clock; also the memory clock (engine `mem_clk` equals `clk`).
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: host message word valid.
- `in_ready` out 1: block accepts a message word this cycle.
- `in_data` in 32: message word.
- `out_valid` out 1: digest word valid.
- `out_ready` in 1: host accepts the digest word.
- `out_data` out 32: digest word, h0 first.
- `busy` out 1: a job is in progress (any state except LOAD).
- `err` out 1: sticky; engine failed to leave IDLE after start.
- `start` out 1: one-cycle start pulse to the engine.
- `done` in 1: engine done; high whenever the engine is idle.
- `message_addr` out 16: constant `MSG_BASE`.
- `output_addr` out 16: constant `OUT_BASE`.
- `mem_we` in 1: engine write enable.
- `mem_addr` in 16: engine word address.
- `mem_write_data` in 32: engine write data.
- `mem_read_data` out 32: registered read data to the engine.

## Operation
Memory:
- `DEPTH` x 32 array, one port, muxed by state.
- Write takes effect at the posedge where the write enable is high.
- Read: the address sampled at posedge N appears on the read-data register after posedge N and holds through cycle N+1.
- An out-of-range write is dropped. An out-of-range read returns 0.
- Owner per state: host in LOAD, engine in START/WAIT_BUSY/WAIT_DONE, drain logic in DRAIN.

FSM states: LOAD, START, WAIT_BUSY, WAIT_DONE, DRAIN.
- **LOAD:**
  - `in_ready`=1.
  - Each handshake writes `in_data` to `MSG_BASE+cnt`, then increments `cnt`.
  - When the word with `cnt = NUM_OF_WORDS-1` is accepted: clear `cnt` and go to START.
  - Engine `mem_we` is ignored in this state.
- **START:**
  - `start`=1 for exactly this one cycle.
  - Go to WAIT_BUSY and clear the timeout counter `tmo`.
- **WAIT_BUSY:**
  - `done`=0 sampled: go to WAIT_DONE.
  - Otherwise increment `tmo`. When `tmo` reaches 4 with `done` still 1: set `err`=1 and go to LOAD.
- **WAIT_DONE:**
  - Engine owns memory.
  - `done`=1 sampled: go to DRAIN with `k`=0.
  - No timeout in this state.
- **DRAIN:**
  - Reads `OUT_BASE+k` for k=0..7, each presented on `out_data` with `out_valid`.
  - After the handshake on k=7: go to LOAD.
- `err` clears only on reset. It never blocks a new job.
- Arithmetic: `MSG_BASE+cnt` and `OUT_BASE+k` are 16-bit and wrap modulo 2^16. A wrapped address lands out of range when `DEPTH` < 65536.

## Timing
- Reset values:
  - `in_ready`=0, `out_valid`=0, `out_data`=0, `busy`=0, `err`=0, `start`=0, `mem_read_data`=0.
  - State LOAD, `cnt`=`k`=`tmo`=0.
  - `in_ready` rises the first cycle after reset release.
  - Memory contents are not reset.
- Reset mid-job (any state): outputs return to reset values immediately and the partial job is discarded. The memory keeps whatever was written.
- LOAD throughput: one word per cycle while `in_valid`=1.
- START is asserted the cycle after the last message word is accepted.
- DRAIN timing:
  - Read for k is issued on entry or after the handshake for k-1.
  - `out_valid` rises 2 cycles after issue, leaving one idle cycle between words.
  - `out_data` and `out_valid` hold stable while `out_ready`=0.
- Engine read latency matches the engine's one-cycle pipeline: `mem_read_data` in cycle N+1 equals `mem[mem_addr@N]`. A same-cycle read and write at one address returns the old data.

## Test plan
- **Reset:**
  - Stimulus: assert `reset_n`=0 in the middle of DRAIN.
  - Response: all outputs 0 at once. After release, `in_ready`=1 and `busy`=0.
- **Load/start:**
  - Stimulus: 20 words 32'h00000001..32'h00000014 streamed back-to-back.
  - Response: exactly one `start` pulse, in the cycle after word 20. `mem[0..19]` holds the words.
- **Engine stub:**
  - Stimulus: the stub drops `done`, reads addresses 0..19, then writes `32'h11111111*(k+1)` to `OUT_BASE+k`.
  - Response: it receives the loaded words with 1-cycle latency. Drain then emits 8 words 32'h11111111..32'h88888888 in order.
- **Backpressure:**
  - Stimulus: `out_ready` toggles 0/1 every 3 cycles during drain.
  - Response: no word is lost or duplicated, and `out_data` is stable while stalled.
- **Timeout:**
  - Stimulus: the stub holds `done`=1 after `start`.
  - Response: `err`=1 four cycles later, the FSM is back in LOAD, and a following good job completes with `err` still 1.
- **Full integration:**
  - Stimulus: the real engine with `NUM_OF_WORDS`=20 and a message from the bench's SHA-256 model.
  - Response: the 8 drained words equal the model's digest.

Source files
------------

// File: rtl/sha256_host_mem.sv
// Host-side responder for the SHA-256 engine: owns the shared word memory, loads the
// message from a host stream, runs the start/done handshake and streams the digest back.
module sha256_host_mem #(
    parameter int          NUM_OF_WORDS = 20,
    parameter int          DEPTH        = 64,
    parameter logic [15:0] MSG_BASE     = 16'h0000,
    parameter logic [15:0] OUT_BASE     = 16'h0020
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy,
    output logic        err,
    output logic        start,
    input  logic        done,
    output logic [15:0] message_addr,
    output logic [15:0] output_addr,
    input  logic        mem_we,
    input  logic [15:0] mem_addr,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_read_data
);

    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [16:0] DEPTH_L  = 17'(DEPTH);
    localparam logic [15:0] LAST_CNT = 16'(NUM_OF_WORDS - 1);

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_START,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  k_q, k_d;
    logic [2:0]  tmo_q, tmo_d;
    logic        cap_q, cap_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_data_q, out_data_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;
    logic        start_q, start_d;
    logic [31:0] rdata_q;

    logic        port_we_s;
    logic [15:0] port_addr_s;
    logic [31:0] port_wdata_s;
    logic        port_in_range_s;

    logic [31:0] mem_q [DEPTH];

    // Next-state and output-register logic for the job sequencer
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        k_d         = k_q;
        tmo_d       = tmo_q;
        cap_d       = cap_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        err_d       = err_q;
        case (state_q)
            ST_LOAD: begin
                if (in_valid && in_ready_q) begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_d   = 16'd0;
                        state_d = ST_START;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_START: begin
                tmo_d   = 3'd0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!done) begin
                    state_d = ST_WAIT_DONE;
                end else if (tmo_q == 3'd3) begin
                    err_d   = 1'b1;
                    tmo_d   = 3'd0;
                    state_d = ST_LOAD;
                end else begin
                    tmo_d = tmo_q + 3'd1;
                end
            end
            ST_WAIT_DONE: begin
                if (done) begin
                    k_d         = 4'd0;
                    cap_d       = 1'b0;
                    out_valid_d = 1'b0;
                    state_d     = ST_DRAIN;
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_DRAIN: begin
                // The read for the next word is issued in the handshake cycle itself
                if (out_valid_q) begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        if (k_q == 4'd7) begin
                            k_d     = 4'd0;
                            state_d = ST_LOAD;
                        end else begin
                            k_d   = k_q + 4'd1;
                            cap_d = 1'b1;
                        end
                    end else begin
                        out_valid_d = 1'b1;
                    end
                end else if (cap_q) begin
                    out_data_d  = rdata_q;
                    out_valid_d = 1'b1;
                    cap_d       = 1'b0;
                end else begin
                    cap_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
        in_ready_d = (state_d == ST_LOAD);
        busy_d     = (state_d != ST_LOAD);
        start_d    = (state_d == ST_START);
    end

    // Memory port ownership follows the sequencer state
    always_comb begin
        port_we_s    = 1'b0;
        port_addr_s  = 16'd0;
        port_wdata_s = 32'd0;
        case (state_q)
            ST_LOAD: begin
                port_we_s    = in_valid && in_ready_q;
                port_addr_s  = MSG_BASE + cnt_q;
                port_wdata_s = in_data;
            end
            ST_START, ST_WAIT_BUSY, ST_WAIT_DONE: begin
                port_we_s    = mem_we;
                port_addr_s  = mem_addr;
                port_wdata_s = mem_write_data;
            end
            ST_DRAIN: begin
                port_we_s    = 1'b0;
                port_addr_s  = OUT_BASE + {12'd0, k_d};
                port_wdata_s = 32'd0;
            end
            default: begin
                port_we_s    = 1'b0;
                port_addr_s  = 16'd0;
                port_wdata_s = 32'd0;
            end
        endcase
        port_in_range_s = ({1'b0, port_addr_s} < DEPTH_L);
    end

    // Memory array write; contents survive reset
    always_ff @(posedge clk) begin
        if (port_we_s && port_in_range_s) begin
            mem_q[port_addr_s[AW-1:0]] <= port_wdata_s;
        end
    end

    // Registered read port: returns pre-write data on a same-cycle read/write
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= 32'd0;
        end else if (port_in_range_s) begin
            rdata_q <= mem_q[port_addr_s[AW-1:0]];
        end else begin
            rdata_q <= 32'd0;
        end
    end

    // Sequencer state and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_LOAD;
            cnt_q       <= 16'd0;
            k_q         <= 4'd0;
            tmo_q       <= 3'd0;
            cap_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'd0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            start_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            k_q         <= k_d;
            tmo_q       <= tmo_d;
            cap_q       <= cap_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            start_q     <= start_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign busy          = busy_q;
    assign err           = err_q;
    assign start         = start_q;
    assign message_addr  = MSG_BASE;
    assign output_addr   = OUT_BASE;
    assign mem_read_data = rdata_q;

endmodule

// File: tb/tb_sha256_host_mem.sv
// Directed bench for sha256_host_mem with an inline engine stub driven from the
// stimulus sequence; expected values are hand-computed constants.
module tb_sha256_host_mem;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        busy;
    logic        err;
    logic        start;
    logic        done = 1'b1;
    logic [15:0] message_addr;
    logic [15:0] output_addr;
    logic        mem_we = 1'b0;
    logic [15:0] mem_addr = 16'd0;
    logic [31:0] mem_write_data = 32'd0;
    logic [31:0] mem_read_data;

    int n_checks = 0;
    int n_fail = 0;
    int start_cnt = 0;

    sha256_host_mem #(
        .NUM_OF_WORDS(20),
        .DEPTH(64),
        .MSG_BASE(16'h0000),
        .OUT_BASE(16'h0020)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .busy(busy),
        .err(err),
        .start(start),
        .done(done),
        .message_addr(message_addr),
        .output_addr(output_addr),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // Count cycles in which start is high
    always @(posedge clk) begin
        if (start === 1'b1) start_cnt = start_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_job(input logic [31:0] first);
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data  = first + 32'(i);
            step();
        end
        in_valid = 1'b0;
        in_data  = 32'd0;
        check("start_after_last_word", start, 1'b1);
        check("busy_in_start", busy, 1'b1);
        check("in_ready_in_start", in_ready, 1'b0);
    endtask

    task automatic stub_write_digest(input logic [31:0] unit);
        for (int k = 0; k < 8; k++) begin
            mem_we         = 1'b1;
            mem_addr       = 16'h0020 + 16'(k);
            mem_write_data = unit * 32'(k + 1);
            step();
        end
        mem_we         = 1'b0;
        mem_write_data = 32'd0;
        done           = 1'b1;
    endtask

    task automatic drain(input logic [31:0] unit, input bit bp);
        logic [31:0] prev_d;
        logic        prev_stall;
        int          got;
        int          last_hs;
        prev_d     = 32'd0;
        prev_stall = 1'b0;
        got        = 0;
        last_hs    = 0;
        for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
            out_ready = bp ? (((cyc / 3) % 2) == 1) : 1'b1;
            if (prev_stall) begin
                check("stall_valid_hold", out_valid, 1'b1);
                check("stall_data_hold", out_data, prev_d);
            end
            if (out_valid && out_ready) begin
                check("drain_word", out_data, unit * 32'(got + 1));
                if (!bp && got == 0) check("drain_first_latency", cyc, 3);
                if (!bp && got > 0) check("drain_word_gap", cyc - last_hs, 2);
                last_hs = cyc;
                got++;
            end
            prev_stall = out_valid && !out_ready;
            prev_d     = out_data;
            step();
        end
        out_ready = 1'b0;
        check("drain_count", got, 8);
        check("load_after_drain", in_ready, 1'b1);
        check("idle_after_drain", busy, 1'b0);
    endtask

    initial begin
        #2;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_start", start, 1'b0);
        check("rst_mem_read_data", mem_read_data, 32'd0);
        check("message_addr", message_addr, 16'h0000);
        check("output_addr", output_addr, 16'h0020);
        #10;
        reset_n = 1'b1;
        #1;
        check("in_ready_before_edge", in_ready, 1'b0);
        step();
        check("in_ready_after_release", in_ready, 1'b1);
        check("busy_after_release", busy, 1'b0);

        // Job 1: load, stub reads back, boundary accesses, digest, drain with backpressure
        load_job(32'h0000_0001);
        done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            mem_addr = 16'(i);
            step();
            check("engine_read", mem_read_data, 32'(i + 1));
        end
        check("single_start_pulse", start_cnt, 1);
        mem_we = 1'b1;
        mem_addr = 16'd19;
        mem_write_data = 32'hDEAD_BEEF;
        step();
        check("read_during_write_old", mem_read_data, 32'h0000_0014);
        mem_we = 1'b0;
        step();
        check("read_after_write_new", mem_read_data, 32'hDEAD_BEEF);
        mem_we = 1'b1;
        mem_addr = 16'd67;
        mem_write_data = 32'hCAFE_F00D;
        step();
        mem_we = 1'b0;
        mem_addr = 16'd3;
        step();
        check("oor_write_dropped", mem_read_data, 32'h0000_0004);
        mem_addr = 16'd64;
        step();
        check("oor_read_zero", mem_read_data, 32'd0);
        check("busy_wait_done", busy, 1'b1);
        stub_write_digest(32'h1111_1111);
        drain(32'h1111_1111, 1'b1);

        // Job 2: engine never leaves idle
        load_job(32'h0000_0100);
        for (int i = 0; i < 4; i++) step();
        check("err_not_yet", err, 1'b0);
        check("busy_waiting", busy, 1'b1);
        step();
        check("err_timeout", err, 1'b1);
        check("timeout_back_to_load", in_ready, 1'b1);
        check("timeout_not_busy", busy, 1'b0);

        // Job 3: good job after a timeout, full-rate drain
        load_job(32'h0000_0200);
        done = 1'b0;
        mem_addr = 16'd0;
        step();
        check("job3_read_word0", mem_read_data, 32'h0000_0200);
        stub_write_digest(32'h0101_0101);
        drain(32'h0101_0101, 1'b0);
        check("err_sticky", err, 1'b1);
        check("three_start_pulses", start_cnt, 3);

        // Job 4: reset in the middle of drain
        load_job(32'h0000_0001);
        done = 1'b0;
        step();
        stub_write_digest(32'h1111_1111);
        out_ready = 1'b0;
        for (int c = 0; c < 20 && !out_valid; c++) step();
        check("mid_drain_valid", out_valid, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_out_data", out_data, 32'd0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_err", err, 1'b0);
        check("mid_rst_in_ready", in_ready, 1'b0);
        check("mid_rst_start", start, 1'b0);
        check("mid_rst_mem_read_data", mem_read_data, 32'd0);
        #2;
        reset_n = 1'b1;
        step();
        check("post_rst_in_ready", in_ready, 1'b1);
        check("post_rst_busy", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
